// File: rtl/sd_modulator.sv
// rtl/sd_modulator.sv - first/second order sigma-delta modulator with sample handshake
module sd_modulator #(
  parameter int  W     = 16,
  parameter int  Q     = 14,
  parameter real V     = 1.0,
  parameter int  DIV   = 4,
  parameter int  ORDER = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out,
  output logic                out_strobe,
  output logic                overload,
  input  logic                clear
);

  localparam int VQ = $rtoi(V * (2.0 ** Q));
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = W + 4;
  localparam int SW = W + 5;

  // full-scale feedback and integrator limits, all at the wide sum width
  localparam logic signed [SW-1:0] VQ_S  = SW'(VQ);
  localparam logic signed [SW-1:0] IMAX  = {2'b00, {(W+3){1'b1}}};
  localparam logic signed [SW-1:0] IMIN  = -IMAX;

  logic [CW-1:0]        cnt;
  logic                 tick;
  logic                 accept;
  logic                 hold_full;
  logic signed [W-1:0]  hold_data;
  logic signed [W-1:0]  x;
  logic signed [IW-1:0] i1;
  logic signed [IW-1:0] i2;

  logic signed [W-1:0]  xsel;
  logic signed [SW-1:0] xs_e;
  logic signed [SW-1:0] xc;
  logic signed [SW-1:0] fb;
  logic signed [SW-1:0] i1_e;
  logic signed [SW-1:0] i2_e;
  logic signed [SW-1:0] s1;
  logic signed [SW-1:0] s2;
  logic signed [SW-1:0] i1n;
  logic signed [SW-1:0] i2n;
  logic                 clamp_hit;
  logic                 sat1;
  logic                 sat2;
  logic                 qbit;
  logic                 ovl_event;

  assign tick   = en && (cnt == CW'(DIV - 1));
  assign accept = in_valid && in_ready;

  // tick divider: counts only while enabled, parks at zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // holding register and working register handoff; in_ready mirrors an empty holding slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      x         <= '0;
      in_ready  <= 1'b0;
    end else begin
      if (tick && hold_full) begin
        x <= hold_data;
      end
      if (accept) begin
        hold_data <= in;
      end
      hold_full <= (hold_full && !tick) || accept;
      in_ready  <= !((hold_full && !tick) || accept);
    end
  end

  // loop arithmetic for the current tick; a freshly handed-off sample is used on that same tick
  always_comb begin
    xsel      = hold_full ? hold_data : x;
    xs_e      = {{5{xsel[W-1]}}, xsel};
    xc        = xs_e;
    clamp_hit = 1'b0;
    if (xs_e > VQ_S) begin
      xc        = VQ_S;
      clamp_hit = 1'b1;
    end else if (xs_e < -VQ_S) begin
      xc        = -VQ_S;
      clamp_hit = 1'b1;
    end

    fb   = out ? VQ_S : -VQ_S;
    i1_e = {i1[IW-1], i1};
    i2_e = {i2[IW-1], i2};

    s1   = i1_e + xc - fb;
    i1n  = s1;
    sat1 = 1'b0;
    if (s1 > IMAX) begin
      i1n  = IMAX;
      sat1 = 1'b1;
    end else if (s1 < IMIN) begin
      i1n  = IMIN;
      sat1 = 1'b1;
    end

    s2   = i2_e + i1n - fb;
    i2n  = s2;
    sat2 = 1'b0;
    if (s2 > IMAX) begin
      i2n  = IMAX;
      sat2 = 1'b1;
    end else if (s2 < IMIN) begin
      i2n  = IMIN;
      sat2 = 1'b1;
    end

    // zero quantizes to 1
    qbit      = (ORDER == 2) ? !i2n[SW-1] : !i1n[SW-1];
    ovl_event = clamp_hit || sat1 || ((ORDER == 2) && sat2);
  end

  // integrators, output bit and strobe advance only on the tick clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1         <= '0;
      i2         <= '0;
      out        <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= tick;
      if (tick) begin
        i1  <= i1n[IW-1:0];
        out <= qbit;
        if (ORDER == 2) begin
          i2 <= i2n[IW-1:0];
        end
      end
    end
  end

  // sticky overload; a set event on the same clock beats clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overload <= 1'b0;
    end else if (tick && ovl_event) begin
      overload <= 1'b1;
    end else if (clear) begin
      overload <= 1'b0;
    end
  end

endmodule

// File: doc/sd_modulator.md
SD_MODULATOR -- requirements
Module: sd_modulator

Interface
REQ-001 Parameter W, default 16: input sample width, signed two's complement.
REQ-002 Parameter Q, default 14: fractional bits of the input sample.
REQ-003 Parameter V, default 1.0 (real): full-scale feedback magnitude; VQ = $rtoi(V*2**Q), VQ SHALL be < 2**(W-1).
REQ-004 Parameter DIV, default 4, >=1: system clocks per modulator tick.
REQ-005 Parameter ORDER, default 2, legal values 1 or 2: loop order.
REQ-006 clk  input  1  system clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  modulator run enable.
REQ-009 in  input  W  signed sample, Q fractional bits.
REQ-010 in_valid  input  1  sample offered.
REQ-011 in_ready  output  1  holding register empty; sample accepted when in_valid && in_ready.
REQ-012 out  output  1  modulated bitstream: 1 = +VQ, 0 = -VQ.
REQ-013 out_strobe  output  1  one-clock pulse when out updates.
REQ-014 overload  output  1  sticky flag: input clamp or integrator saturation occurred.
REQ-015 clear  input  1  synchronous clear of overload.

Function
REQ-016 Tick divider: counter 0..DIV-1 advances every clk while en=1; tick = (count==DIV-1); wraps to 0; while en=0 counter held at 0 and no tick.
REQ-017 Holding register: on accept, sample stored and in_ready driven low on the next clock.
REQ-018 On tick with holding register full: sample moves to the working register x, holding register empties, in_ready high on the next clock; a sample accepted on a tick clock is not used until the following tick.
REQ-019 x is held (zero-order hold) until replaced; never cleared by ticks.
REQ-020 Clamp: x used as xc = min(max(x, -VQ), +VQ); clamping during a tick sets overload.
REQ-021 Feedback FB = +VQ if out=1, else -VQ, using out before the tick.
REQ-022 Integrators i1, i2 are W+4 bits, signed, saturating at +/-(2**(W+3)-1); saturation sets overload.
REQ-023 Per tick: i1' = sat(i1 + xc - FB); when ORDER=2, i2' = sat(i2 + i1' - FB).
REQ-024 Quantizer per tick: out' = (i1' >= 0) for ORDER=1, (i2' >= 0) for ORDER=2; zero maps to 1.
REQ-025 out, i1, i2 register on the tick clock; out_strobe is high on the clock after each tick, else low.
REQ-026 Latency: a sample in x reaches the quantizer on the same tick; out is visible one clk after that tick.
REQ-027 en=0: i1, i2, out, x held; the holding register still accepts one sample.
REQ-028 overload stays high until clear=1; if clear and a set event share a clock, set wins.
REQ-029 Arithmetic: all sums computed at W+5 bits before saturation; no wrap-around permitted.

Reset
REQ-030 While reset=1: out=0, out_strobe=0, overload=0, in_ready=0, divider=0, i1=i2=0, x=0, holding register empty.
REQ-031 in_ready goes high on the first clk after reset deasserts; the first tick occurs DIV clocks after reset deasserts with en=1.
REQ-032 Reset asserted mid-operation aborts immediately; a pending held sample is discarded.

Verification (W=16, Q=14, V=1.0, VQ=16384, DIV=4)
REQ-033 ORDER=1, x=0 -> bits after reset: 1,1,0,1,0,...; exactly 512+/-1 ones in 1024 ticks.
REQ-034 ORDER=2, in=8192 (0.5) -> 768+/-2 ones in 1024 ticks; overload stays 0.
REQ-035 in=20000 -> used as 16384; overload=1 on the first tick; after 8 ticks all bits 1; clear=1 with no new event -> overload=0 next clk.
REQ-036 Handshake: two back-to-back valid samples -> first accepted; in_ready low until the next tick plus one clk; second accepted then; out_strobe period exactly 4 clk.
REQ-037 en low for 10 clk mid-stream -> no out_strobe, out/i1/i2 unchanged; resume -> first tick 4 clk after en rises.
REQ-038 Reset asserted during an active held sample -> all outputs at reset values asynchronously; the held sample is not applied after release.
